// File: rtl/i2s_feat_pkg.sv
// Shared types and helpers for the I2S audio feature datapath.
package i2s_feat_pkg;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int SAT_MAX_W      = 32;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CAPTURE   = 3'd1,
      ST_MEAN      = 3'd2,
      ST_DRAIN     = 3'd3,
      ST_WAIT_FEAT = 3'd4
   } state_t;

   // a - b clamped to the signed range of a w-bit value; operands are pre-sign-extended, w < SAT_MAX_W.
   function automatic logic signed [SAT_MAX_W-1:0] sat_sub(
      input logic signed [SAT_MAX_W-1:0] a,
      input logic signed [SAT_MAX_W-1:0] b,
      input int                          w
   );
      logic signed [SAT_MAX_W-1:0] hi;
      logic signed [SAT_MAX_W-1:0] lo;
      logic signed [SAT_MAX_W-1:0] d;
      hi = $signed((SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1));
      lo = ~hi;
      d  = a - b;
      if (d > hi) return hi;
      if (d < lo) return lo;
      return d;
   endfunction

endpackage

// File: rtl/i2s_sat_sub.sv
// Output stage of the drain path: registered (sample - mean) with saturation, plus framing flags.
module i2s_sat_sub
   import i2s_feat_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  sample_vld,
   input  logic                  sample_first,
   input  logic                  sample_last,
   input  logic [DATA_WIDTH-1:0] sample,
   input  logic [DATA_WIDTH-1:0] mean,
   output logic [DATA_WIDTH-1:0] feat_data,
   output logic                  feat_vld,
   output logic                  feat_first,
   output logic                  feat_last
);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         feat_data  <= '0;
         feat_vld   <= 1'b0;
         feat_first <= 1'b0;
         feat_last  <= 1'b0;
      end else begin
         feat_vld   <= sample_vld;
         feat_first <= sample_vld && sample_first;
         feat_last  <= sample_vld && sample_last;
         if (sample_vld)
            feat_data <= DATA_WIDTH'(sat_sub(SAT_MAX_W'($signed(sample)),
                                             SAT_MAX_W'($signed(mean)), DATA_WIDTH));
      end
   end

endmodule

// File: rtl/i2s_frame_scheduler.sv
// Frame sequencer for the I2S feature path: capture one channel into the FIFO, compute the mean,
// drain as a mean-subtracted stream, then wait for the feature engines before the next frame.
module i2s_frame_scheduler
   import i2s_feat_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int ADDR_W     = 8,
   parameter bit CHANNEL    = 1'b0
) (
   input  logic                  i_sys_clk,
   input  logic                  i_sys_rst,
   input  logic                  i_enable,
   input  logic [DATA_WIDTH-1:0] i_left_data,
   input  logic                  i_left_vld,
   input  logic [DATA_WIDTH-1:0] i_right_data,
   input  logic                  i_right_vld,
   output logic                  o_fifo_wr_en,
   output logic [DATA_WIDTH-1:0] o_fifo_wr_data,
   input  logic                  i_fifo_full,
   output logic                  o_fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
   input  logic                  i_fifo_empty,
   output logic [DATA_WIDTH-1:0] o_mean,
   output logic [DATA_WIDTH-1:0] o_feat_data,
   output logic                  o_feat_vld,
   output logic                  o_feat_first,
   output logic                  o_feat_last,
   input  logic                  i_feat_done,
   output logic                  o_frame_done,
   output logic [15:0]           o_frame_cnt,
   output logic [15:0]           o_drop_cnt,
   output logic                  o_busy
);

   localparam int              FRAME_LEN   = 2 ** ADDR_W;
   localparam int              SUM_W       = DATA_WIDTH + ADDR_W;
   localparam logic [ADDR_W:0] FRAME_LEN_C = (ADDR_W + 1)'(FRAME_LEN);
   localparam logic [ADDR_W:0] CNT_ONE     = (ADDR_W + 1)'(1);

   state_t                       state, state_nxt;
   logic [ADDR_W:0]              wr_cnt, rd_issued;
   logic signed [SUM_W-1:0]      sum;
   logic signed [DATA_WIDTH-1:0] sel_data;
   logic                         sel_vld, frame_full, accept, drop, frame_end;
   logic                         rd_pend, rd_pend_first, rd_pend_last;

   // NOTE: every variable gets a default at the top of always_comb, so no path infers a latch.
   always_comb begin
      sel_vld      = CHANNEL ? i_right_vld  : i_left_vld;
      sel_data     = CHANNEL ? i_right_data : i_left_data;
      frame_full   = (wr_cnt == FRAME_LEN_C);
      accept       = (state == ST_CAPTURE) && sel_vld && !i_fifo_full && !frame_full;
      drop         = sel_vld && (state != ST_IDLE) && !accept;
      o_fifo_rd_en = (state == ST_DRAIN) && !i_fifo_empty && (rd_issued < FRAME_LEN_C);
      frame_end    = (state == ST_WAIT_FEAT) && i_feat_done;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE:      if (i_enable) state_nxt = ST_CAPTURE;
         ST_CAPTURE:   if (frame_full) state_nxt = ST_MEAN;
         ST_MEAN:      state_nxt = ST_DRAIN;
         ST_DRAIN:     if (o_feat_vld && o_feat_last) state_nxt = ST_WAIT_FEAT;
         ST_WAIT_FEAT: if (i_feat_done) state_nxt = i_enable ? ST_CAPTURE : ST_IDLE;
         default:      state_nxt = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignment so all registers see pre-edge values.
   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) state <= ST_IDLE;
      else           state <= state_nxt;
   end

   always_ff @(posedge i_sys_clk) begin
      if (i_sys_rst) begin
         o_fifo_wr_en   <= 1'b0;
         o_fifo_wr_data <= '0;
         o_mean         <= '0;
         o_frame_done   <= 1'b0;
         o_frame_cnt    <= '0;
         o_drop_cnt     <= '0;
         sum            <= '0;
         wr_cnt         <= '0;
         rd_issued      <= '0;
         rd_pend        <= 1'b0;
         rd_pend_first  <= 1'b0;
         rd_pend_last   <= 1'b0;
      end else begin
         o_fifo_wr_en <= accept;
         if (accept) begin
            o_fifo_wr_data <= sel_data;
            sum            <= sum + SUM_W'(sel_data);
            wr_cnt         <= wr_cnt + CNT_ONE;
         end
         // Mean is latched and the frame bookkeeping rearmed in the single MEAN cycle.
         if (state == ST_MEAN) begin
            o_mean    <= DATA_WIDTH'(sum >>> ADDR_W);
            sum       <= '0;
            wr_cnt    <= '0;
            rd_issued <= '0;
         end
         if (o_fifo_rd_en) rd_issued <= rd_issued + CNT_ONE;
         rd_pend       <= o_fifo_rd_en;
         rd_pend_first <= o_fifo_rd_en && (rd_issued == '0);
         rd_pend_last  <= o_fifo_rd_en && (rd_issued == FRAME_LEN_C - CNT_ONE);
         o_frame_done  <= frame_end;
         if (frame_end) o_frame_cnt <= o_frame_cnt + 16'd1;
         if (drop && (o_drop_cnt != 16'hFFFF)) o_drop_cnt <= o_drop_cnt + 16'd1;
      end
   end

   assign o_busy = (state != ST_IDLE);

   i2s_sat_sub #(.DATA_WIDTH(DATA_WIDTH)) u_sat_sub (
      .sys_clk      (i_sys_clk),
      .sys_rst      (i_sys_rst),
      .sample_vld   (rd_pend),
      .sample_first (rd_pend_first),
      .sample_last  (rd_pend_last),
      .sample       (i_fifo_rd_data),
      .mean         (o_mean),
      .feat_data    (o_feat_data),
      .feat_vld     (o_feat_vld),
      .feat_first   (o_feat_first),
      .feat_last    (o_feat_last)
   );

endmodule
